// File: rtl/bdm_link_manager.sv
// BDM link manager: drives sync attempts with timeout, range check, backoff and
// bounded retry, then holds the rounded bit time while the link is up.
module bdm_link_manager #(
  parameter logic [31:0] TIMEOUT   = 32'd200000,
  parameter logic [15:0] BACKOFF   = 16'd1024,
  parameter logic [3:0]  MAX_RETRY = 4'd3,
  parameter logic [31:0] MIN_SYNC  = 32'd128,
  parameter logic [31:0] MAX_SYNC  = 32'd8388479,
  parameter logic        AUTO_SYNC = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        resync_req,
  input  logic        cmd_error,
  input  logic        sync_done,
  input  logic [31:0] sync_length,
  output logic        sync_start,
  output logic [15:0] bit_time,
  output logic        link_up,
  output logic        link_error,
  output logic [3:0]  retry_count,
  output logic        busy
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_WAIT_LOW  = 3'd2;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd3;
  localparam logic [2:0] ST_CHECK     = 3'd4;
  localparam logic [2:0] ST_BACKOFF   = 3'd5;
  localparam logic [2:0] ST_LINKED    = 3'd6;
  localparam logic [2:0] ST_FAILED    = 3'd7;

  logic [2:0]  state;
  logic [31:0] timer;
  logic [15:0] backoff_cnt;
  logic        req;
  logic        in_wait;
  logic        timed_out;
  logic        length_ok;
  logic        attempt_fail;
  logic        backoff_done;

  always_comb begin
    req          = resync_req | cmd_error;
    in_wait      = (state == ST_WAIT_LOW) || (state == ST_WAIT_HIGH);
    timed_out    = timer >= TIMEOUT;
    length_ok    = (sync_length >= MIN_SYNC) && (sync_length <= MAX_SYNC);
    // Timeout wins over a sync_done edge seen in the same cycle.
    attempt_fail = (in_wait && timed_out) || ((state == ST_CHECK) && !length_ok);
    backoff_done = ({1'b0, backoff_cnt} + 17'd1) >= {1'b0, BACKOFF};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      timer       <= '0;
      backoff_cnt <= '0;
      bit_time    <= '0;
      retry_count <= '0;
    end else if (attempt_fail) begin
      if (retry_count < MAX_RETRY) begin
        retry_count <= retry_count + 4'd1;
        backoff_cnt <= '0;
        state       <= ST_BACKOFF;
      end else begin
        state <= ST_FAILED;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (req || AUTO_SYNC) begin
            retry_count <= '0;
            state       <= ST_START;
          end
        end
        ST_START: begin
          timer <= '0;
          state <= ST_WAIT_LOW;
        end
        ST_WAIT_LOW: begin
          timer <= timer + 32'd1;
          if (!sync_done) state <= ST_WAIT_HIGH;
        end
        ST_WAIT_HIGH: begin
          timer <= timer + 32'd1;
          if (sync_done) state <= ST_CHECK;
        end
        ST_CHECK: begin
          bit_time <= 16'((sync_length + 32'd64) >> 7);
          state    <= ST_LINKED;
        end
        ST_BACKOFF: begin
          if (backoff_done) state <= ST_START;
          else backoff_cnt <= backoff_cnt + 16'd1;
        end
        default: begin
          if (req) begin
            retry_count <= '0;
            state       <= ST_START;
          end
        end
      endcase
    end
  end

  always_comb begin
    sync_start = (state == ST_START);
    link_up    = (state == ST_LINKED);
    link_error = (state == ST_FAILED);
    busy       = (state == ST_START) || in_wait || (state == ST_CHECK) ||
                 (state == ST_BACKOFF);
  end

endmodule

// File: tb/tb_bdm_link_manager.sv
// Self-checking bench for bdm_link_manager: a small sync-unit driver plus a
// sequence-level model of retries, range checks and bit-time rounding.
module tb_bdm_link_manager;

  localparam int unsigned TO   = 1000;
  localparam int unsigned BO   = 16;
  localparam int unsigned MR   = 2;
  localparam logic [31:0] MINS = 32'd128;
  localparam logic [31:0] MAXS = 32'd8388479;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        resync_req = 1'b0;
  logic        cmd_error = 1'b0;
  logic        sync_done = 1'b1;
  logic [31:0] sync_length = '0;
  logic        sync_start;
  logic [15:0] bit_time;
  logic        link_up;
  logic        link_error;
  logic [3:0]  retry_count;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  int          extra_starts = 0;
  logic [15:0] model_bt = '0;

  always #5 clk = ~clk;

  bdm_link_manager #(
    .TIMEOUT(32'd1000), .BACKOFF(16'd16), .MAX_RETRY(4'd2),
    .MIN_SYNC(32'd128), .MAX_SYNC(32'd8388479), .AUTO_SYNC(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .resync_req(resync_req), .cmd_error(cmd_error),
    .sync_done(sync_done), .sync_length(sync_length), .sync_start(sync_start),
    .bit_time(bit_time), .link_up(link_up), .link_error(link_error),
    .retry_count(retry_count), .busy(busy)
  );

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (sync_start === 1'b1) begin
        seen = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // Sync unit: drop done one cycle after the start pulse, raise it h cycles later.
  task automatic serve(input logic [31:0] len, input int h, input bit poke);
    @(negedge clk);
    sync_done = 1'b0;
    for (int i = 0; i < h; i++) begin
      @(negedge clk);
      if (sync_start === 1'b1) extra_starts++;
      resync_req = poke && (i == h / 2);
      cmd_error  = poke && (i == h / 2);
    end
    resync_req  = 1'b0;
    cmd_error   = 1'b0;
    sync_length = len;
    sync_done   = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (sync_start === 1'b1) extra_starts++;
    end
  endtask

  // Sequence model: first in-range length links; more than MR failures ends in FAILED.
  task automatic run_seq(input logic [31:0] lens[$], input int h, output bit ok,
                         output logic [15:0] ebt, output logic [3:0] erc,
                         output bit elink);
    int fails = 0;
    bit seen;
    ok = 1'b1;
    elink = 1'b0;
    ebt = model_bt;
    foreach (lens[i]) begin
      wait_start(seen);
      if (!seen) begin
        ok = 1'b0;
        return;
      end
      serve(lens[i], h, 1'b0);
      if (lens[i] >= MINS && lens[i] <= MAXS) begin
        ebt = 16'((lens[i] + 32'd64) / 32'd128);
        elink = 1'b1;
        break;
      end
      fails++;
      if (fails > MR) break;
    end
    erc = elink ? 4'(fails) : 4'(fails - 1);
    model_bt = ebt;
  endtask

  task automatic pulse_resync();
    resync_req = 1'b1;
    @(negedge clk);
    resync_req = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({sync_start, bit_time, link_up, link_error, retry_count, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got st=%0b bt=%0d up=%0b err=%0b rc=%0d busy=%0b want all 0",
               sync_start, bit_time, link_up, link_error, retry_count, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (sync_start !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL auto_start got st=%0b busy=%0b want 1 1", sync_start, busy);
    end
  endtask

  task automatic test_reset_release();
    logic [31:0] lens[$] = '{32'd1280};
    bit ok, el;
    logic [15:0] ebt;
    logic [3:0] erc;
    run_seq(lens, 300, ok, ebt, erc, el);
    checks++;
    if (!ok || bit_time !== 16'd10 || link_up !== 1'b1 || retry_count !== 4'd0) begin
      errors++;
      $display("FAIL first_link got ok=%0b bt=%0d up=%0b rc=%0d want 1 10 1 0",
               ok, bit_time, link_up, retry_count);
    end
  endtask

  task automatic test_rounding();
    logic [31:0] cases[2] = '{32'd1343, 32'd1344};
    logic [15:0] want[2] = '{16'd10, 16'd11};
    bit ok, el;
    logic [15:0] ebt;
    logic [3:0] erc;
    for (int i = 0; i < 2; i++) begin
      logic [31:0] lens[$];
      lens = '{cases[i]};
      pulse_resync();
      run_seq(lens, 4, ok, ebt, erc, el);
      checks++;
      if (!ok || bit_time !== want[i] || link_up !== 1'b1) begin
        errors++;
        $display("FAIL rounding len=%0d got bt=%0d up=%0b want %0d 1",
                 cases[i], bit_time, link_up, want[i]);
      end
    end
  endtask

  task automatic test_range();
    logic [31:0] firsts[3] = '{32'd100, 32'd127, 32'd8388480};
    logic [31:0] seconds[3] = '{32'd1280, 32'd128, 32'd8388479};
    bit ok, el;
    logic [15:0] ebt;
    logic [3:0] erc;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] lens[$];
      lens = '{firsts[i], seconds[i]};
      pulse_resync();
      checks++;
      if (link_up !== 1'b0 || retry_count !== 4'd0 || sync_start !== 1'b1) begin
        errors++;
        $display("FAIL resync_enter got up=%0b rc=%0d st=%0b want 0 0 1",
                 link_up, retry_count, sync_start);
      end
      run_seq(lens, 3, ok, ebt, erc, el);
      checks++;
      if (!ok || retry_count !== 4'd1 || link_up !== 1'b1 || bit_time !== ebt) begin
        errors++;
        $display("FAIL range case=%0d got rc=%0d up=%0b bt=%0d want 1 1 %0d",
                 i, retry_count, link_up, bit_time, ebt);
      end
    end
  endtask

  task automatic test_timeout();
    int starts[$];
    int cyc = 0;
    pulse_resync();
    sync_done = 1'b0;
    while (cyc < 4000 && link_error !== 1'b1) begin
      if (sync_start === 1'b1) starts.push_back(cyc);
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (starts.size() != 3 || link_error !== 1'b1 || retry_count !== 4'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout got starts=%0d err=%0b rc=%0d busy=%0b want 3 1 2 0",
               starts.size(), link_error, retry_count, busy);
    end
    for (int i = 1; i < starts.size(); i++) begin
      checks++;
      if (starts[i] - starts[i-1] < TO + BO || starts[i] - starts[i-1] > TO + BO + 14) begin
        errors++;
        $display("FAIL timeout_spacing got %0d want %0d..%0d",
                 starts[i] - starts[i-1], TO + BO, TO + BO + 14);
      end
    end
    sync_done = 1'b1;
  endtask

  task automatic test_all_invalid();
    logic [31:0] lens[$] = '{32'd0, 32'd127, 32'd8388480};
    bit ok, el;
    logic [15:0] ebt;
    logic [3:0] erc;
    pulse_resync();
    checks++;
    if (link_error !== 1'b0 || retry_count !== 4'd0 || sync_start !== 1'b1) begin
      errors++;
      $display("FAIL failed_exit got err=%0b rc=%0d st=%0b want 0 0 1",
               link_error, retry_count, sync_start);
    end
    run_seq(lens, 2, ok, ebt, erc, el);
    checks++;
    if (!ok || link_error !== 1'b1 || retry_count !== erc || bit_time !== ebt) begin
      errors++;
      $display("FAIL all_invalid got err=%0b rc=%0d bt=%0d want 1 %0d %0d",
               link_error, retry_count, bit_time, erc, ebt);
    end
  endtask

  task automatic test_cmd_error();
    logic [31:0] lens[$] = '{32'd1280};
    bit ok, el;
    logic [15:0] ebt;
    logic [3:0] erc;
    pulse_resync();
    run_seq(lens, 3, ok, ebt, erc, el);
    resync_req = 1'b1;
    cmd_error  = 1'b1;
    @(negedge clk);
    resync_req = 1'b0;
    cmd_error  = 1'b0;
    checks++;
    if (link_up !== 1'b0 || sync_start !== 1'b1 || retry_count !== 4'd0) begin
      errors++;
      $display("FAIL cmd_error_restart got up=%0b st=%0b rc=%0d want 0 1 0",
               link_up, sync_start, retry_count);
    end
    extra_starts = 0;
    serve(32'd2560, 8, 1'b1);
    checks++;
    if (extra_starts != 0 || link_up !== 1'b1 || bit_time !== 16'd20) begin
      errors++;
      $display("FAIL busy_ignore got extra=%0d up=%0b bt=%0d want 0 1 20",
               extra_starts, link_up, bit_time);
    end
    model_bt = 16'd20;
  endtask

  task automatic test_random();
    bit ok, el;
    logic [15:0] ebt;
    logic [3:0] erc;
    for (int n = 0; n < 10; n++) begin
      logic [31:0] lens[$];
      lens = {};
      for (int k = 0; k <= MR; k++) begin
        case ($urandom_range(0, 3))
          0: lens.push_back($urandom_range(0, 127));
          1: lens.push_back($urandom_range(32'd8388480, 32'hFFFF_FFFF));
          default: lens.push_back($urandom_range(128, 8388479));
        endcase
      end
      pulse_resync();
      run_seq(lens, int'($urandom_range(1, 12)), ok, ebt, erc, el);
      checks++;
      if (!ok || link_up !== el || link_error !== !el || retry_count !== erc ||
          bit_time !== ebt || busy !== 1'b0) begin
        errors++;
        $display("FAIL random n=%0d got up=%0b err=%0b rc=%0d bt=%0d want %0b %0b %0d %0d",
                 n, link_up, link_error, retry_count, bit_time, el, !el, erc, ebt);
      end
    end
  endtask

  task automatic test_reset_mid();
    pulse_resync();
    @(negedge clk);
    sync_done = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_bt = '0;
    checks++;
    if ({sync_start, bit_time, link_up, link_error, retry_count, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid got st=%0b bt=%0d up=%0b err=%0b rc=%0d busy=%0b want all 0",
               sync_start, bit_time, link_up, link_error, retry_count, busy);
    end
    sync_done = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (sync_start !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_restart got st=%0b want 1", sync_start);
    end
    serve(32'd1280, 4, 1'b0);
    checks++;
    if (link_up !== 1'b1 || bit_time !== 16'd10) begin
      errors++;
      $display("FAIL reset_mid_relink got up=%0b bt=%0d want 1 10", link_up, bit_time);
    end
  endtask

  initial begin
    test_reset();
    test_reset_release();
    test_rounding();
    test_range();
    test_timeout();
    test_all_invalid();
    test_cmd_error();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
